// File: rtl/jz_bus_arbiter_pkg.sv
// jz_bus_arbiter_pkg: shared state encodings, default widths and timeout for the bus arbiter
package jz_bus_arbiter_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_IF  = 2'd1,
    GNT_MEM = 2'd2
  } arb_state_t;
  localparam int ADDR_W_DEF  = 32;
  localparam int DATA_W_DEF  = 32;
  localparam int TIMEOUT_DEF = 15;
  localparam int SEL_W       = 4;
  localparam int CNT_W       = 8;
endpackage

// File: rtl/jz_bus_arbiter.sv
// jz_bus_arbiter: IF/MEM to single-slave bus arbiter with wait timeout; ARB_ROUND_ROBIN_EN enables round-robin on contention
module jz_bus_arbiter
  import jz_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic              if_err,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [SEL_W-1:0]  mem_sel,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_ack,
  output logic              mem_err,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              s_req,
  output logic              s_we,
  output logic [SEL_W-1:0]  s_sel,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  input  logic              s_ack,
  input  logic [DATA_W-1:0] s_rdata,
  output logic              stall_req
);
  arb_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             g_if, g_mem, timeout, pick_mem;
  // grants are masked during reset so an abandoned access never completes
  assign g_if     = (state == GNT_IF) & ~rst;
  assign g_mem    = (state == GNT_MEM) & ~rst;
  assign timeout  = cnt == CNT_W'(TIMEOUT - 1);
  assign if_ack   = g_if & s_ack;
  assign if_err   = g_if & ~s_ack & timeout;
  assign mem_ack  = g_mem & s_ack;
  assign mem_err  = g_mem & ~s_ack & timeout;
  assign if_rdata  = if_ack ? s_rdata : '0;
  assign mem_rdata = mem_ack ? s_rdata : '0;
  assign s_req   = g_if | g_mem;
  assign s_we    = g_mem & mem_we;
  assign s_sel   = g_mem ? mem_sel : g_if ? {SEL_W{1'b1}} : '0;
  assign s_addr  = g_mem ? mem_addr : g_if ? if_addr : '0;
  assign s_wdata = g_mem ? mem_wdata : '0;
  assign stall_req = ~rst & ((if_req & ~if_ack) | (mem_req & ~mem_ack));
`ifdef ARB_ROUND_ROBIN_EN
  logic last_mem;
  assign pick_mem = mem_req & (~if_req | ~last_mem);
  always_ff @(posedge clk) begin
    if (rst) last_mem <= 1'b0;
    else if (state == IDLE && (mem_req | if_req)) last_mem <= pick_mem;
  end
`else
  assign pick_mem = mem_req;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (state == IDLE) begin
      cnt   <= '0;
      state <= pick_mem ? GNT_MEM : if_req ? GNT_IF : IDLE;
    end else if (s_ack | timeout | ~(g_if | g_mem)) begin
      state <= IDLE;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_jz_bus_arbiter.sv
// tb_jz_bus_arbiter: scoreboard bench for jz_bus_arbiter with a latency-programmable slave model
module tb_jz_bus_arbiter;
  logic        clk = 0, rst = 1;
  logic        if_req = 0, mem_req = 0, mem_we = 0, s_ack = 0;
  logic [31:0] if_addr = 0, mem_addr = 0, mem_wdata = 0, s_rdata;
  logic [3:0]  mem_sel = 0;
  logic        if_ack, if_err, mem_ack, mem_err, s_req, s_we, stall_req;
  logic [31:0] if_rdata, mem_rdata, s_addr, s_wdata;
  logic [3:0]  s_sel;
  typedef struct {
    bit          is_mem;
    bit          err;
    logic [31:0] addr;
    bit          we;
    logic [3:0]  sel;
    logic [31:0] wdata;
  } exp_t;
  exp_t sb[$];
  int errors = 0, checks = 0;
  int lat = 1, wcnt = 0, stall_cnt = 0, sreq_cnt = 0;
  bit slave_manual = 0;
  always #5 clk = ~clk;
  jz_bus_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_err(if_err), .if_rdata(if_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_err(mem_err), .mem_rdata(mem_rdata),
    .s_req(s_req), .s_we(s_we), .s_sel(s_sel), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_ack(s_ack), .s_rdata(s_rdata), .stall_req(stall_req)
  );
  assign s_rdata = s_ack ? (s_addr ^ 32'h5A5A_0000) : 32'hBAD0_BAD0;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic exp_t mk(bit m, bit err, logic [31:0] a, bit we, logic [3:0] sel, logic [31:0] wd);
    exp_t e;
    e.is_mem = m; e.err = err; e.addr = a; e.we = we; e.sel = sel; e.wdata = wd;
    return e;
  endfunction
  task automatic pop_cmp(bit m, logic ack, logic err, logic [31:0] rdata);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_resp: master_mem=%0d ack=%b err=%b, required no response", m, ack, err);
      return;
    end
    e = sb.pop_front();
    chk("resp_master", 32'(m), 32'(e.is_mem));
    chk("resp_err", 32'(err), 32'(e.err));
    chk("resp_ack", 32'(ack), 32'(!e.err));
    chk("resp_s_addr", s_addr, e.addr);
    if (!e.err) chk("resp_rdata", rdata, e.addr ^ 32'h5A5A_0000);
    if (m) begin
      chk("resp_s_we", 32'(s_we), 32'(e.we));
      chk("resp_s_sel", 32'(s_sel), 32'(e.sel));
      chk("resp_s_wdata", s_wdata, e.wdata);
    end else chk("resp_s_we_if", 32'(s_we), 0);
  endtask
  initial forever begin
    @(posedge clk);
    #1;
    if (!slave_manual) begin
      if (s_req) begin
        if (wcnt == lat) s_ack = 1;
        else begin
          s_ack = 0;
          wcnt++;
        end
      end else begin
        s_ack = 0;
        wcnt  = 0;
      end
    end
  end
  always @(negedge clk) begin
    if (stall_req) stall_cnt++;
    if (s_req) sreq_cnt++;
    if (!if_ack) chk("if_rdata_zero", if_rdata, 0);
    if (!mem_ack) chk("mem_rdata_zero", mem_rdata, 0);
    if (if_ack | if_err) pop_cmp(0, if_ack, if_err, if_rdata);
    if (mem_ack | mem_err) pop_cmp(1, mem_ack, mem_err, mem_rdata);
  end
  task automatic master(bit m, int n, logic [31:0] base, bit we, logic [3:0] sel, logic [31:0] wd);
    for (int i = 0; i < n; i++) begin
      int t = 0;
      if (m) begin
        mem_req = 1; mem_addr = base + 32'(4 * i); mem_we = we; mem_sel = sel; mem_wdata = wd;
      end else begin
        if_req = 1; if_addr = base + 32'(4 * i);
      end
      do begin
        @(negedge clk);
        t++;
      end while (!(m ? (mem_ack | mem_err) : (if_ack | if_err)) && t < 100);
      if (t >= 100) begin
        checks++;
        errors++;
        $display("FAIL wait_resp: master_mem=%0d no response in 100 cycles, required a response", m);
      end
      @(posedge clk);
      #1;
    end
    if (m) begin
      mem_req = 0; mem_we = 0; mem_sel = 0; mem_wdata = 0;
    end else if_req = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end
  initial begin
    if_req = 1; mem_req = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_s_req", 32'(s_req), 0);
    chk("rst_stall", 32'(stall_req), 0);
    chk("rst_acks", {28'd0, if_ack, if_err, mem_ack, mem_err}, 0);
    chk("rst_s_addr", s_addr, 0);
    @(posedge clk);
    #1;
    if_req = 0; mem_req = 0; rst = 0;
    @(negedge clk);
    chk("idle_s_req", 32'(s_req), 0);
    chk("idle_s_sel", 32'(s_sel), 0);
    chk("idle_stall", 32'(stall_req), 0);
    @(posedge clk);
    #1;
    lat = 1; stall_cnt = 0;
    sb.push_back(mk(1, 0, 32'h2000, 0, 4'hF, 0));
    sb.push_back(mk(0, 0, 32'h300, 0, 0, 0));
    fork
      master(1, 1, 32'h2000, 0, 4'hF, 0);
      master(0, 1, 32'h300, 0, 0, 0);
    join
    repeat (2) @(posedge clk);
    chk("contend_stall_cycles", 32'(stall_cnt), 5);
    #1;
`ifdef ARB_ROUND_ROBIN_EN
    sb.push_back(mk(1, 0, 32'h4000, 0, 4'h1, 0));
    sb.push_back(mk(0, 0, 32'h500, 0, 0, 0));
    sb.push_back(mk(1, 0, 32'h4004, 0, 4'h1, 0));
    sb.push_back(mk(0, 0, 32'h504, 0, 0, 0));
`else
    sb.push_back(mk(1, 0, 32'h4000, 0, 4'h1, 0));
    sb.push_back(mk(1, 0, 32'h4004, 0, 4'h1, 0));
    sb.push_back(mk(0, 0, 32'h500, 0, 0, 0));
    sb.push_back(mk(0, 0, 32'h504, 0, 0, 0));
`endif
    fork
      master(1, 2, 32'h4000, 0, 4'h1, 0);
      master(0, 2, 32'h500, 0, 0, 0);
    join
    repeat (2) @(posedge clk);
    #1;
    lat = 2; stall_cnt = 0;
    sb.push_back(mk(0, 0, 32'h100, 0, 0, 0));
    master(0, 1, 32'h100, 0, 0, 0);
    repeat (2) @(posedge clk);
    chk("fetch_stall_cycles", 32'(stall_cnt), 3);
    #1;
    lat = 3;
    sb.push_back(mk(1, 0, 32'h600, 1, 4'b0011, 32'hDEAD_BEEF));
    fork
      master(1, 1, 32'h600, 1, 4'b0011, 32'hDEAD_BEEF);
      repeat (6) begin
        @(negedge clk);
        if (s_req) begin
          chk("wr_s_we", 32'(s_we), 1);
          chk("wr_s_sel", 32'(s_sel), 32'h3);
          chk("wr_s_wdata", s_wdata, 32'hDEAD_BEEF);
        end
      end
    join
    repeat (2) @(posedge clk);
    #1;
    lat = 1000; sreq_cnt = 0;
    sb.push_back(mk(1, 1, 32'h700, 0, 4'hF, 0));
    master(1, 1, 32'h700, 0, 4'hF, 0);
    @(negedge clk);
    chk("timeout_s_req_dropped", 32'(s_req), 0);
    chk("timeout_grant_cycles", 32'(sreq_cnt), 15);
    @(posedge clk);
    #1;
    lat = 1;
    sb.push_back(mk(0, 0, 32'h140, 0, 0, 0));
    master(0, 1, 32'h140, 0, 0, 0);
    @(posedge clk);
    #1;
    lat = 1000;
    mem_req = 1; mem_addr = 32'h800; mem_sel = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    rst = 1; mem_req = 0;
    @(negedge clk);
    chk("midrst_s_req", 32'(s_req), 0);
    chk("midrst_stall", 32'(stall_req), 0);
    chk("midrst_acks", {30'd0, mem_ack, mem_err}, 0);
    @(posedge clk);
    #1;
    rst = 0; slave_manual = 1; s_ack = 1;
    repeat (3) begin
      @(negedge clk);
      chk("late_ack_s_req", 32'(s_req), 0);
      chk("late_ack_resp", {28'd0, if_ack, if_err, mem_ack, mem_err}, 0);
    end
    @(posedge clk);
    #1;
    s_ack = 0; slave_manual = 0; wcnt = 0;
    repeat (3) @(posedge clk);
    chk("sb_drained", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
